// File: rtl/button_cmd_ctrl.sv
// Turns debounced deal/hit/stand button levels into single game commands, gated by game state.
// Latency: command valid one cycle after the press is sampled; outputs are all registered.
// Backpressure: a pending command is held stable until cmd_valid & cmd_ready; buttons are ignored meanwhile.
module button_cmd_ctrl #(
    parameter int unsigned HOLDOFF_CYCLES = 650_000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       deal,
    input  logic       hit,
    input  logic       stand,
    input  logic [1:0] game_state,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    input  logic       cmd_ready,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_ARMED        = 2'd0,
        ST_PENDING      = 2'd1,
        ST_RELEASE_WAIT = 2'd2,
        ST_HOLDOFF      = 2'd3
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_DEAL  = 2'b01;
    localparam logic [1:0] CMD_HIT   = 2'b10;
    localparam logic [1:0] CMD_STAND = 2'b11;

    localparam logic [1:0] GS_IDLE        = 2'b00;
    localparam logic [1:0] GS_PLAYER_TURN = 2'b01;
    localparam logic [1:0] GS_RESULT      = 2'b11;

    localparam bit              NO_HOLDOFF = (HOLDOFF_CYCLES == 0);
    localparam logic [CNT_W-1:0] LOAD_VAL  = NO_HOLDOFF ? '0 : CNT_W'(HOLDOFF_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [7:0]       drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       any_btn;
    logic [1:0] cand_code;
    logic       cand_legal;

    assign any_btn = deal | hit | stand;

    // Fixed priority deal > hit > stand, then check the candidate against the game phase.
    always_comb begin
        cand_code  = CMD_STAND;
        cand_legal = 1'b0;
        if (deal) begin
            cand_code = CMD_DEAL;
        end else if (hit) begin
            cand_code = CMD_HIT;
        end
        if (cand_code == CMD_DEAL) begin
            cand_legal = (game_state == GS_IDLE) || (game_state == GS_RESULT);
        end else begin
            cand_legal = (game_state == GS_PLAYER_TURN);
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ARMED: begin
                if (any_btn) begin
                    if (cand_legal) begin
                        state_d = ST_PENDING;
                        code_d  = cand_code;
                    end else begin
                        state_d = ST_RELEASE_WAIT;
                        if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end
                end
            end
            ST_PENDING: begin
                if (cmd_ready) begin
                    state_d = ST_RELEASE_WAIT;
                    code_d  = CMD_NONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!any_btn) begin
                    if (NO_HOLDOFF) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = LOAD_VAL;
                    end
                end
            end
            ST_HOLDOFF: begin
                // Any activity during holdoff is treated as bounce and restarts the quiet window.
                if (any_btn) begin
                    cnt_d = LOAD_VAL;
                end else if (cnt_q == '0) begin
                    state_d = ST_ARMED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ARMED;
                code_d  = CMD_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARMED;
            code_q  <= CMD_NONE;
            drop_q  <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_valid = (state_q == ST_PENDING);
    assign cmd_code  = code_q;
    assign busy      = (state_q != ST_ARMED);
    assign drop_cnt  = drop_q;

endmodule
